// File: rtl/timer_channel_param.sv
// Parametrised timer channel: N-bit counter, two compares, prescaler/external tick, TMO, flags, ADC trigger.
// Optional TIMER_CASCADE_EN: cascade_in replaces the cks=4 prescaler tap and ovf_out exposes overflow events.
module timer_channel_param #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned DIV_MAX_LOG2 = 10,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [2:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [2:0]       rd_addr,
   output logic [WIDTH-1:0] rd_data,
   input  logic             tmci,
   input  logic             tmri,
`ifdef TIMER_CASCADE_EN
   input  logic             cascade_in,
   output logic             ovf_out,
`endif
   output logic             tmo,
   output logic             cmia,
   output logic             cmib,
   output logic             ovi,
   output logic             adc_req
);

   logic [WIDTH-1:0]        tcnt, tcora, tcorb;
   logic [7:0]              tcr, tcsr;
   logic [DIV_MAX_LOG2-1:0] presc;
   logic [SYNC_STAGES-1:0]  tmci_sync, tmri_sync;
   logic                    tmci_hist, tmri_hist;

   logic [WIDTH-1:0]        tcnt_nxt, tcora_nxt, tcorb_nxt;
   logic [7:0]              tcr_nxt, tcsr_nxt;
   logic [2:0]              flags_keep;
   logic [1:0]              act_a, act_b;
   logic                    tmo_nxt;
   logic                    tmci_rise, tmci_fall, tmri_rise;
   logic                    tick, tick_ok, cma, cmb, cmp_clr, ovf_evt;
   logic                    tcnt_wr, tcora_wr, tcorb_wr, tcr_wr, tcsr_wr;

   assign tmci_rise = tmci_sync[SYNC_STAGES-1] & ~tmci_hist;
   assign tmci_fall = ~tmci_sync[SYNC_STAGES-1] & tmci_hist;
   assign tmri_rise = tmri_sync[SYNC_STAGES-1] & ~tmri_hist;

   assign tcnt_wr  = wr_en && (wr_addr == 3'd0);
   assign tcora_wr = wr_en && (wr_addr == 3'd1);
   assign tcorb_wr = wr_en && (wr_addr == 3'd2);
   assign tcr_wr   = wr_en && (wr_addr == 3'd3);
   assign tcsr_wr  = wr_en && (wr_addr == 3'd4);

`ifdef TIMER_CASCADE_EN
   assign ovf_out = ovf_evt;
`endif

   // Tick source, match events and next-state of every register
   always_comb begin
      tick = 1'b0;
      case (tcr[2:0])
         3'd1:    tick = 1'b1;
         3'd2:    tick = &presc[2:0];
         3'd3:    tick = &presc[5:0];
`ifdef TIMER_CASCADE_EN
         3'd4:    tick = cascade_in;
`else
         3'd4:    tick = &presc;
`endif
         3'd5:    tick = tmci_rise;
         3'd6:    tick = tmci_fall;
         3'd7:    tick = tmci_rise | tmci_fall;
         default: tick = 1'b0;
      endcase

      // A CPU write to TCNT swallows the events of its cycle
      tick_ok = tick & ~tcnt_wr;
      cma     = tick_ok && (tcnt == tcora);
      cmb     = tick_ok && (tcnt == tcorb);
      cmp_clr = ((tcr[4:3] == 2'd1) && cma) || ((tcr[4:3] == 2'd2) && cmb);
      ovf_evt = tick_ok && (&tcnt) && !cmp_clr;

      tcnt_nxt = tcnt;
      if (tcnt_wr)                                tcnt_nxt = wr_data;
      else if ((tcr[4:3] == 2'd3) && tmri_rise)   tcnt_nxt = '0;
      else if (cmp_clr)                           tcnt_nxt = '0;
      else if (tick)                              tcnt_nxt = tcnt + WIDTH'(1);

      tcora_nxt = tcora_wr ? wr_data : tcora;
      tcorb_nxt = tcorb_wr ? wr_data : tcorb;
      tcr_nxt   = tcr_wr ? wr_data[7:0] : tcr;

      // Flags: write can only clear, and a new event wins over that clear
      flags_keep     = tcsr_wr ? (tcsr[7:5] & wr_data[7:5]) : tcsr[7:5];
      tcsr_nxt[7:5]  = flags_keep | {cma, cmb, ovf_evt};
      tcsr_nxt[4:0]  = tcsr_wr ? wr_data[4:0] : tcsr[4:0];

      act_a   = cma ? tcsr[1:0] : 2'b00;
      act_b   = cmb ? tcsr[3:2] : 2'b00;
      tmo_nxt = tmo;
      if ((act_a == 2'b11) || (act_b == 2'b11))      tmo_nxt = ~tmo;
      else if ((act_a == 2'b10) || (act_b == 2'b10)) tmo_nxt = 1'b1;
      else if ((act_a == 2'b01) || (act_b == 2'b01)) tmo_nxt = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt      <= '0;
         tcora     <= '1;
         tcorb     <= '1;
         tcr       <= '0;
         tcsr      <= '0;
         presc     <= '0;
         tmci_sync <= '0;
         tmri_sync <= '0;
         tmci_hist <= 1'b0;
         tmri_hist <= 1'b0;
         tmo       <= 1'b0;
         cmia      <= 1'b0;
         cmib      <= 1'b0;
         ovi       <= 1'b0;
         adc_req   <= 1'b0;
      end else begin
         tcnt      <= tcnt_nxt;
         tcora     <= tcora_nxt;
         tcorb     <= tcorb_nxt;
         tcr       <= tcr_nxt;
         tcsr      <= tcsr_nxt;
         presc     <= presc + DIV_MAX_LOG2'(1);
         tmci_sync <= {tmci_sync[SYNC_STAGES-2:0], tmci};
         tmri_sync <= {tmri_sync[SYNC_STAGES-2:0], tmri};
         tmci_hist <= tmci_sync[SYNC_STAGES-1];
         tmri_hist <= tmri_sync[SYNC_STAGES-1];
         tmo       <= tmo_nxt;
         cmia      <= tcsr_nxt[7] & tcr_nxt[5];
         cmib      <= tcsr_nxt[6] & tcr_nxt[6];
         ovi       <= tcsr_nxt[5] & tcr_nxt[7];
         adc_req   <= cma & tcsr[4];
      end
   end

   // Register readback; control registers are zero-extended
   always_comb begin
      rd_data = '0;
      case (rd_addr)
         3'd0:    rd_data = tcnt;
         3'd1:    rd_data = tcora;
         3'd2:    rd_data = tcorb;
         3'd3:    rd_data = WIDTH'(tcr);
         3'd4:    rd_data = WIDTH'(tcsr);
         default: rd_data = '0;
      endcase
   end

endmodule
